// File: rtl/alu_operand_entry.sv
// alu_operand_entry
// Front-end input controller for the 4-bit ALU board. Debounces the raw
// ENTER and CLEAR buttons and walks the user through entering operand A,
// operand B and the opcode from the slide switches, then issues a one-cycle
// eval strobe to the ALU.
//
// Ports
//   clk        system clock (single domain)
//   rst        synchronous, active-high reset
//   sw         slide switches; sampled directly when ENTER is accepted
//   btn_enter  raw ENTER button, asynchronous, active-high
//   btn_clear  raw CLEAR button, asynchronous, active-high
//   a          captured operand A
//   b          captured operand B
//   opcode     captured opcode (sw[2:0])
//   eval       one-cycle strobe: operands and opcode are complete
//   stage      entry stage for display: 00=A, 01=B, 10=OP, 11=EVAL/SHOW
//
// Handshake: there is no back-pressure. eval is a registered strobe that is
// high for exactly the one cycle the FSM spends in S_EVAL; a, b and opcode are
// already stable in that cycle and stay stable until the next capture or
// clear. stage exposes the FSM position for display and observation.

module alu_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] opcode,
    output logic       eval,
    output logic [1:0] stage
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EVAL = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    // Button index 0 is ENTER, index 1 is CLEAR; both get identical conditioning.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       level_q;
    logic [1:0]       level_d;
    logic [1:0]       level_prev_q;
    logic [1:0]       armed_q;
    logic [1:0]       armed_d;
    logic [1:0]       rdy_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press;
    logic             clear_next;

    assign btn_raw = {btn_clear, btn_enter};

    // Debounce: the counter runs only while the synchronised level disagrees
    // with the accepted level; after DEBOUNCE_CYCLES consecutive disagreeing
    // cycles the accepted level flips.
    //
    // armed: the synchroniser flops come out of reset at 0, so a button held
    // through reset would otherwise look like a fresh press. A button is only
    // armed once a real (post-reset) synchronised sample shows it released
    // while its accepted level is low; presses before that are swallowed.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i] = level_q[i];
            cnt_d[i]   = '0;
            armed_d[i] = armed_q[i];
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
            if (rdy_q[1] && !sync2_q[i] && !level_q[i]) begin
                armed_d[i] = 1'b1;
            end
            press[i] = level_q[i] & ~level_prev_q[i] & armed_q[i];
        end
        // Clear press pulse that will be visible next cycle; used to keep eval
        // low when a clear lands in the S_EVAL cycle.
        clear_next = level_d[1] & ~level_q[1] & armed_d[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            armed_q      <= '0;
            rdy_q        <= '0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            armed_q      <= armed_d;
            // rdy_q[1] marks that sync2_q now carries a real sample.
            rdy_q        <= {rdy_q[0], 1'b1};
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
        end
    end

    // Entry FSM with registered outputs.
    state_t     state_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] op_q;
    logic       eval_q;
    logic [1:0] stage_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            eval_q  <= 1'b0;
            stage_q <= 2'b00;
        end else begin
            eval_q <= 1'b0;
            if (press[1]) begin
                // Clear wins over a simultaneous enter.
                state_q <= S_A;
                a_q     <= '0;
                b_q     <= '0;
                op_q    <= '0;
                stage_q <= 2'b00;
            end else begin
                case (state_q)
                    S_A: if (press[0]) begin
                        a_q     <= sw;
                        state_q <= S_B;
                        stage_q <= 2'b01;
                    end
                    S_B: if (press[0]) begin
                        b_q     <= sw;
                        state_q <= S_OP;
                        stage_q <= 2'b10;
                    end
                    S_OP: if (press[0]) begin
                        op_q    <= sw[2:0];
                        state_q <= S_EVAL;
                        stage_q <= 2'b11;
                        eval_q  <= ~clear_next;
                    end
                    S_EVAL: begin
                        state_q <= S_SHOW;
                    end
                    S_SHOW: if (press[0]) begin
                        state_q <= S_A;
                        stage_q <= 2'b00;
                    end
                    default: begin
                        state_q <= S_A;
                        stage_q <= 2'b00;
                    end
                endcase
            end
        end
    end

    assign a      = a_q;
    assign b      = b_q;
    assign opcode = op_q;
    assign eval   = eval_q;
    assign stage  = stage_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
module tb_alu_operand_entry;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] opcode;
  logic       eval;
  logic [1:0] stage;

  alu_operand_entry #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_enter(btn_enter),
    .btn_clear(btn_clear),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .eval     (eval),
    .stage    (stage)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int eval_cnt = 0;
  logic [1:0] prev_stage = 2'b00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Buttons: a level is accepted once the synchronised input (raw delayed by
  // two samples) has disagreed with it for D consecutive cycles. A press is
  // reported the cycle after the accepted level rises, provided the button
  // has been seen released since reset.
  localparam int M_A = 0, M_B = 1, M_OP = 2, M_EVAL = 3, M_SHOW = 4;
  int          m_state = M_A;
  logic [3:0]  m_a = '0;
  logic [3:0]  m_b = '0;
  logic [2:0]  m_op = '0;
  logic [15:0] m_hist [2];   // bit j = raw sample taken j edges ago
  logic        m_acc [2];
  logic        m_armed [2];
  logic        m_press [2];
  int          m_since = 0;  // edges since reset

  task automatic model_reset();
    m_state = M_A; m_a = '0; m_b = '0; m_op = '0; m_since = 0;
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = '0; m_acc[i] = 1'b0; m_armed[i] = 1'b0; m_press[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic raw;
    logic old;
    bit   all_diff;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_press[1]) begin
      m_state = M_A; m_a = '0; m_b = '0; m_op = '0;
    end else begin
      case (m_state)
        M_A:    if (m_press[0]) begin m_a = sw; m_state = M_B; end
        M_B:    if (m_press[0]) begin m_b = sw; m_state = M_OP; end
        M_OP:   if (m_press[0]) begin m_op = sw[2:0]; m_state = M_EVAL; end
        M_EVAL: m_state = M_SHOW;
        default: if (m_press[0]) m_state = M_A;
      endcase
    end
    for (int i = 0; i < 2; i++) begin
      raw = (i == 0) ? btn_enter : btn_clear;
      old = m_acc[i];
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) if (m_hist[i][j] == old) all_diff = 1'b0;
      if (all_diff) m_acc[i] = ~old;
      if (m_since >= 2 && m_hist[i][1] == 1'b0 && old == 1'b0) m_armed[i] = 1'b1;
      m_press[i] = m_acc[i] & ~old & m_armed[i];
      m_hist[i] = {m_hist[i][14:0], raw};
    end
    m_since++;
  endtask

  function automatic int model_stage();
    case (m_state)
      M_A:     return 0;
      M_B:     return 1;
      M_OP:    return 2;
      default: return 3;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One clock: model steps at the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check("model_a", a, m_a);
    check("model_b", b, m_b);
    check("model_opcode", opcode, m_op);
    check("model_stage", stage, model_stage());
    check("model_eval", eval, (m_state == M_EVAL && !m_press[1]) ? 1 : 0);
    if (eval) begin
      eval_cnt++;
      check("eval_after_op", prev_stage, 2);
      check("eval_stage", stage, 3);
    end
    prev_stage = stage;
  endtask

  task automatic press(input bit is_clear, input logic [3:0] v);
    sw = v;
    if (is_clear) btn_clear = 1'b1; else btn_enter = 1'b1;
    repeat (10) tick();
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (10) tick();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit         clr;
    logic [3:0] sw;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [2:0] eop;
    logic [1:0] est;
    int         eev;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int lat;
    int ev0;

    vecs[0]  = '{1'b0, 4'h3, 4'h3, 4'h0, 3'd0, 2'd1, 0};
    vecs[1]  = '{1'b0, 4'h5, 4'h3, 4'h5, 3'd0, 2'd2, 0};
    vecs[2]  = '{1'b0, 4'h0, 4'h3, 4'h5, 3'd0, 2'd3, 1};
    vecs[3]  = '{1'b0, 4'h7, 4'h3, 4'h5, 3'd0, 2'd0, 0};
    vecs[4]  = '{1'b0, 4'hF, 4'hF, 4'h5, 3'd0, 2'd1, 0};
    vecs[5]  = '{1'b0, 4'h1, 4'hF, 4'h1, 3'd0, 2'd2, 0};
    vecs[6]  = '{1'b0, 4'h3, 4'hF, 4'h1, 3'd3, 2'd3, 1};
    vecs[7]  = '{1'b0, 4'h0, 4'hF, 4'h1, 3'd3, 2'd0, 0};
    vecs[8]  = '{1'b0, 4'h9, 4'h9, 4'h1, 3'd3, 2'd1, 0};
    vecs[9]  = '{1'b0, 4'h2, 4'h9, 4'h2, 3'd3, 2'd2, 0};
    vecs[10] = '{1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 2'd0, 0};
    vecs[11] = '{1'b0, 4'h4, 4'h4, 4'h0, 3'd0, 2'd1, 0};
    vecs[12] = '{1'b0, 4'h6, 4'h4, 4'h6, 3'd0, 2'd2, 0};
    vecs[13] = '{1'b0, 4'hE, 4'h4, 4'h6, 3'd6, 2'd3, 1};
    vecs[14] = '{1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 2'd0, 0};

    model_reset();
    rst = 1'b1; sw = 4'h0; btn_enter = 1'b0; btn_clear = 1'b0;

    // ---- reset ----
    repeat (3) tick();
    rst = 1'b0;
    check("reset_a", a, 0);
    check("reset_b", b, 0);
    check("reset_opcode", opcode, 0);
    check("reset_eval", eval, 0);
    check("reset_stage", stage, 0);
    repeat (4) tick();

    // ---- bounce rejection ----
    sw = 4'h3;
    for (int r = 0; r < 4; r++) begin
      btn_enter = (r % 2 == 0);
      repeat (2) tick();
    end
    check("bounce_no_early", stage, 0);
    btn_enter = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (stage == 2'd1) lat = k;
    end
    check("bounce_latency", lat, 7);
    repeat (5) tick();
    btn_enter = 1'b0;
    repeat (10) tick();
    check("bounce_stage", stage, 1);
    check("bounce_a", a, 3);
    press(1'b1, 4'h0);

    // ---- table: full entries, repeat, clear mid-entry, clear from show ----
    for (int v = 0; v < 15; v++) begin
      ev0 = eval_cnt;
      press(vecs[v].clr, vecs[v].sw);
      check($sformatf("vec%0d_a", v), a, vecs[v].ea);
      check($sformatf("vec%0d_b", v), b, vecs[v].eb);
      check($sformatf("vec%0d_opcode", v), opcode, vecs[v].eop);
      check($sformatf("vec%0d_stage", v), stage, vecs[v].est);
      check($sformatf("vec%0d_evals", v), eval_cnt - ev0, vecs[v].eev);
    end

    // ---- clear landing in the eval cycle ----
    press(1'b0, 4'h1);
    press(1'b0, 4'h2);
    ev0 = eval_cnt;
    sw = 4'h5;
    btn_enter = 1'b1;
    tick();
    btn_clear = 1'b1;
    repeat (12) tick();
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (10) tick();
    check("clr_eval_suppressed", eval_cnt - ev0, 0);
    check("clr_eval_stage", stage, 0);
    check("clr_eval_a", a, 0);

    // ---- reset mid-sequence ----
    press(1'b0, 4'h7);
    press(1'b0, 4'h2);
    check("pre_rst_stage", stage, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_a", a, 0);
    check("rst_mid_b", b, 0);
    check("rst_mid_opcode", opcode, 0);
    check("rst_mid_eval", eval, 0);
    check("rst_mid_stage", stage, 0);

    // ---- ENTER held across reset ----
    sw = 4'h1;
    btn_enter = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("held_no_pulse_stage", stage, 0);
    check("held_no_pulse_a", a, 0);
    btn_enter = 1'b0;
    repeat (10) tick();
    press(1'b0, 4'h8);
    check("held_then_press_stage", stage, 1);
    check("held_then_press_a", a, 8);

    // ---- simultaneous enter and clear in S_B ----
    sw = 4'h5;
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    repeat (10) tick();
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (10) tick();
    check("simul_stage", stage, 0);
    check("simul_a", a, 0);
    check("simul_b", b, 0);

    // ---- randomized stimulus against the model ----
    repeat (500) begin
      sw        = 4'($urandom_range(0, 15));
      btn_enter = 1'($urandom_range(0, 1));
      btn_clear = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 80) == 0);
      repeat ($urandom_range(1, 8)) begin
        tick();
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
